mem_refill_bridge: RTL

Memory-side responder for the instruction-cache refill port: accepts a single-cycle refill request (`rd_req`, `rd_addr`), fetches the aligned 64-bit line as two 32-bit beats over an AXI4-Lite read channel, and returns it with a one-cycle `ret_valid` pulse. It sits between the cache's miss path and the core's memory bus. It serialises refills, reports bus errors and timeouts, and optionally serves repeat requests from a one-entry line buffer.

---
 rtl/npc_refill_pkg.sv | 17 +
 rtl/refill_linebuf.sv | 39 +++
 rtl/mem_refill_bridge.sv | 135 +++++++++++++
 3 files changed

// File: rtl/npc_refill_pkg.sv
// Shared types and constants for the instruction-cache refill path.
package npc_refill_pkg;

    localparam int REFILL_LINE_W = 64;
    localparam int REFILL_BEAT_W = 32;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        AR0,
        R0,
        AR1,
        R1,
        RESP
    } refill_state_t;

endpackage

// File: rtl/refill_linebuf.sv
// One-entry refill line buffer: tag compare, data store, invalidate.
module refill_linebuf
    import npc_refill_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inv,
    input  logic                     wr,
    input  logic                     clr,
    input  logic [31:3]              wr_tag,
    input  logic [REFILL_LINE_W-1:0] wr_data,
    input  logic [31:3]              rd_tag,
    output logic                     hit,
    output logic [REFILL_LINE_W-1:0] rd_data
);

    logic                     vld;
    logic [31:3]              tag;
    logic [REFILL_LINE_W-1:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            tag  <= '0;
            data <= '0;
        end else if (inv || clr) begin
            vld <= 1'b0;
        end else if (wr) begin
            vld  <= 1'b1;
            tag  <= wr_tag;
            data <= wr_data;
        end
    end

    // A same-cycle invalidate suppresses the hit so the request goes to the bus.
    assign hit     = vld && !inv && (tag == rd_tag);
    assign rd_data = data;

endmodule

// File: rtl/mem_refill_bridge.sv
// Refill responder: fetches a 64-bit line as two AXI4-Lite read beats.
// Optional one-entry line buffer enabled by defining MEM_REFILL_LINEBUF_EN.
//
// state | meaning
// IDLE  | waiting for rd_req
// AR0   | beat 0 address phase (base)
// R0    | beat 0 data phase, timeout counting
// AR1   | beat 1 address phase (base+4)
// R1    | beat 1 data phase, timeout counting
// RESP  | one-cycle ret_valid pulse
module mem_refill_bridge
    import npc_refill_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [3:0]               rd_wstrb,
    input  logic [63:0]              rd_addr,
    input  logic                     inv,
    output logic                     ret_valid,
    output logic [REFILL_LINE_W-1:0] ret_data,
    output logic                     ret_err,
    output logic                     busy,
    output logic [31:0]              araddr,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [REFILL_BEAT_W-1:0] rdata,
    input  logic [1:0]               rresp,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    refill_state_t            state, state_nxt;
    logic [31:3]              base;
    logic [REFILL_BEAT_W-1:0] lo_word;
    logic                     err_flag;
    logic [7:0]               to_cnt;
    logic                     timeout;
    logic                     lb_hit;
    logic [REFILL_LINE_W-1:0] lb_data;
    logic                     unused_ok;

    assign unused_ok = ^{rd_wstrb, rd_addr[63:32], rd_addr[2:0], inv};
    assign timeout   = (to_cnt == TO_LAST);

`ifdef MEM_REFILL_LINEBUF_EN
    refill_linebuf u_linebuf (
        .clk     (clk),
        .rst     (rst),
        .inv     (inv),
        .wr      ((state == RESP) && !err_flag),
        .clr     ((state == RESP) && err_flag),
        .wr_tag  (base),
        .wr_data (ret_data),
        .rd_tag  (rd_addr[31:3]),
        .hit     (lb_hit),
        .rd_data (lb_data)
    );
`else
    assign lb_hit  = 1'b0;
    assign lb_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_req) state_nxt = lb_hit ? RESP : AR0;
            AR0:     if (arready) state_nxt = R0;
            R0:      if (rvalid) state_nxt = AR1;
                     else if (timeout) state_nxt = RESP;
            AR1:     if (arready) state_nxt = R1;
            R1:      if (rvalid || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ret_data is only loaded on the edge into RESP so it holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base     <= '0;
            lo_word  <= '0;
            ret_data <= '0;
            err_flag <= 1'b0;
            to_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (rd_req) begin
                    base     <= rd_addr[31:3];
                    err_flag <= 1'b0;
                    if (lb_hit) ret_data <= lb_data;
                end
                AR0, AR1: to_cnt <= '0;
                R0: begin
                    if (rvalid) begin
                        lo_word  <= rdata;
                        err_flag <= err_flag | (rresp != AXI_RESP_OKAY);
                    end else if (timeout) begin
                        err_flag <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                R1: begin
                    if (rvalid) begin
                        ret_data <= {rdata, lo_word};
                        err_flag <= err_flag | (rresp != AXI_RESP_OKAY);
                    end else if (timeout) begin
                        err_flag <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arvalid   = (state == AR0) || (state == AR1);
    assign rready    = (state == R0) || (state == R1);
    assign araddr    = {base, (state == AR1) || (state == R1), 2'b00};
    assign ret_valid = (state == RESP);
    assign ret_err   = (state == RESP) && err_flag;
    assign busy      = (state != IDLE);

endmodule
